// File: rtl/gp_cmd_scheduler.sv
// Command scheduler for the 8x8 rasterizer: two-requester round-robin
// arbiter, shared command FIFO and an issue FSM paced by frame_start and a drain count.
module gp_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int FS_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic [19:0]                   req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [19:0]                   req1_data,
  output logic                          req1_ready,
  output logic [1:0]                    gp_command,
  output logic [2:0]                    gp_x1,
  output logic [2:0]                    gp_y1,
  output logic [2:0]                    gp_x2,
  output logic [2:0]                    gp_y2,
  output logic [2:0]                    gp_rect_width,
  output logic [2:0]                    gp_rect_height,
  output logic                          gp_command_valid,
  input  logic                          gp_frame_start,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(FS_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_FS,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [19:0]   cmd_q, cmd_d;
  logic [5:0]    drain_q, drain_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [19:0]   mem_q [FIFO_DEPTH];

  logic        full, empty, gnt1;
  logic        push0, push1, push, pop;
  logic [AW:0] level;
  logic [19:0] push_data;

  assign level = wr_q - rd_q;
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (wr_q == rd_q);

  // On a tie the requester not served by the last push wins.
  assign gnt1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = !full && !gnt1;
  assign req1_ready = !full && gnt1;
  assign push0      = req0_valid && req0_ready;
  assign push1      = req1_valid && req1_ready;
  assign push       = push0 || push1;
  assign push_data  = push1 ? req1_data : req0_data;
  assign pop        = (state_q == IDLE) && !empty;

  assign wr_d   = wr_q + {{AW{1'b0}}, push};
  assign rd_d   = rd_q + {{AW{1'b0}}, pop};
  assign last_d = push ? push1 : last_q;
  assign cmd_d  = pop ? mem_q[rd_q[AW-1:0]] : cmd_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cmd_q   <= '0;
      drain_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cmd_q   <= cmd_d;
      drain_q <= drain_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_FS;
      end
      WAIT_FS: begin
        if (gp_frame_start) begin
          // The frame_start cycle is the first of the 64 drain cycles.
          drain_d = 6'd62;
          state_d = DRAIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TW'(FS_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 6'd0) state_d = IDLE;
        else drain_d = drain_q - 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gp_command_valid = (state_q == ISSUE);
    busy             = (state_q != IDLE) || pop;
    frame_done       = (state_q == DRAIN) && (drain_q == 6'd0);
    timeout_err      = err_q;
    fifo_level       = level;
    {gp_command, gp_x1, gp_y1, gp_x2, gp_y2,
     gp_rect_width, gp_rect_height} = cmd_q;
  end

endmodule

// File: tb/tb_gp_cmd_scheduler.sv
// Directed bench for gp_cmd_scheduler: a per-cycle vector table for
// arbitration/FIFO/timeout plus sequences for drain timing and reset.
module tb_gp_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0, v1, fs;
  logic [19:0] d0, d1;
  logic        r0, r1;
  logic [1:0]  gp_command;
  logic [2:0]  gp_x1, gp_y1, gp_x2, gp_y2, gp_w, gp_h;
  logic        cv, busy, fd, err;
  logic [2:0]  lvl;
  logic [19:0] gp_all;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gp_cmd_scheduler #(.FIFO_DEPTH(4), .FS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .gp_command(gp_command), .gp_x1(gp_x1), .gp_y1(gp_y1),
    .gp_x2(gp_x2), .gp_y2(gp_y2),
    .gp_rect_width(gp_w), .gp_rect_height(gp_h),
    .gp_command_valid(cv), .gp_frame_start(fs),
    .busy(busy), .frame_done(fd), .fifo_level(lvl),
    .timeout_err(err)
  );

  assign gp_all = {gp_command, gp_x1, gp_y1, gp_x2, gp_y2, gp_w, gp_h};

  typedef struct {
    logic        v0, v1;
    logic        r0, r1;
    logic [2:0]  lvl;
    logic        cv, busy, err;
    logic [19:0] cmd;
  } vec_t;

  localparam logic [19:0] D0 = 20'h5A5A5;
  localparam logic [19:0] D1 = 20'h3C3C3;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " level"}, 32'(lvl), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " cmd_valid"}, 32'(cv), 32'd0);
    chk({tag, " frame_done"}, 32'(fd), 32'd0);
    chk({tag, " timeout_err"}, 32'(err), 32'd0);
    chk({tag, " payload"}, 32'(gp_all), 32'd0);
    chk({tag, " req0_ready"}, 32'(r0), 32'd1);
    chk({tag, " req1_ready"}, 32'(r1), 32'd0);
  endtask

  // Leaves the bench 2 time units into cycle 0 after reset release.
  task automatic do_reset();
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; fs = 1'b0;
    d0 = '0; d1 = '0;
    @(posedge clk);
    #2;
    chk_reset_vals("rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  vec_t tbl[10];
  int   strobes[$];
  int   fdones[$];
  int   fs_at;
  logic busy67, busy68;

  initial begin
    // Both requesters valid from reset; no frame_start, so the first
    // command times out and the FSM moves on to the next queued one.
    tbl[0] = '{1, 1, 1, 0, 3'd0, 0, 0, 0, 20'h0};
    tbl[1] = '{1, 1, 0, 1, 3'd1, 0, 1, 0, 20'h0};
    tbl[2] = '{1, 1, 1, 0, 3'd1, 1, 1, 0, D0};
    tbl[3] = '{1, 1, 0, 1, 3'd2, 0, 1, 0, 20'h0};
    tbl[4] = '{1, 1, 1, 0, 3'd3, 0, 1, 0, 20'h0};
    tbl[5] = '{1, 1, 0, 0, 3'd4, 0, 1, 0, 20'h0};
    tbl[6] = '{1, 1, 0, 0, 3'd4, 0, 1, 0, 20'h0};
    tbl[7] = '{1, 1, 0, 0, 3'd4, 0, 1, 1, 20'h0};
    tbl[8] = '{1, 1, 0, 1, 3'd3, 1, 1, 1, D1};
    tbl[9] = '{1, 1, 0, 0, 3'd4, 0, 1, 1, 20'h0};

    do_reset();
    for (int c = 0; c < 10; c++) begin
      v0 = tbl[c].v0; v1 = tbl[c].v1;
      d0 = D0; d1 = D1; fs = 1'b0;
      #1;
      chk($sformatf("rr c%0d req0_ready", c), 32'(r0), 32'(tbl[c].r0));
      chk($sformatf("rr c%0d req1_ready", c), 32'(r1), 32'(tbl[c].r1));
      chk($sformatf("rr c%0d level", c), 32'(lvl), 32'(tbl[c].lvl));
      chk($sformatf("rr c%0d cmd_valid", c), 32'(cv), 32'(tbl[c].cv));
      chk($sformatf("rr c%0d busy", c), 32'(busy), 32'(tbl[c].busy));
      chk($sformatf("rr c%0d timeout_err", c), 32'(err), 32'(tbl[c].err));
      if (tbl[c].cv)
        chk($sformatf("rr c%0d payload", c), 32'(gp_all), 32'(tbl[c].cmd));
      next_cycle();
    end

    // Single command with a processor raising frame_start at T+2.
    do_reset();
    strobes.delete(); fdones.delete();
    busy67 = 1'b0; busy68 = 1'b1;
    for (int c = 0; c < 72; c++) begin
      v0 = (c == 0); d0 = 20'h55000; fs = (c == 4);
      #1;
      if (c == 0) chk("single req0_ready", 32'(r0), 32'd1);
      if (cv) begin
        strobes.push_back(c);
        chk("single command", 32'(gp_command), 32'd1);
        chk("single x1", 32'(gp_x1), 32'd2);
        chk("single y1", 32'(gp_y1), 32'd5);
      end
      if (fd) fdones.push_back(c);
      if (c == 67) busy67 = busy;
      if (c == 68) busy68 = busy;
      next_cycle();
    end
    chk("single strobes", 32'(strobes.size()), 32'd1);
    if (strobes.size() == 1) chk("single strobe cyc", 32'(strobes[0]), 32'd2);
    chk("single fdones", 32'(fdones.size()), 32'd1);
    if (fdones.size() == 1) chk("single fd cyc", 32'(fdones[0]), 32'd67);
    chk("single busy c67", 32'(busy67), 32'd1);
    chk("single busy c68", 32'(busy68), 32'd0);
    chk("single no timeout", 32'(err), 32'd0);

    // Three queued commands, stray frame_start in IDLE and DRAIN.
    do_reset();
    strobes.delete(); fdones.delete();
    fs_at = -1;
    for (int c = 0; c < 210; c++) begin
      v0 = (c < 3); d0 = 20'h10000 + 20'(c);
      fs = (c == fs_at) || (c == 0) || (c == 1) || (c == 30) || (c == 100);
      #1;
      if (cv) begin
        chk($sformatf("b2b payload %0d", strobes.size()), 32'(gp_all),
            32'h10000 + 32'(strobes.size()));
        strobes.push_back(c);
        fs_at = c + 2;
      end
      if (fd) fdones.push_back(c);
      next_cycle();
    end
    chk("b2b strobes", 32'(strobes.size()), 32'd3);
    chk("b2b fdones", 32'(fdones.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < strobes.size())
        chk($sformatf("b2b strobe %0d cyc", i), 32'(strobes[i]), 32'(2 + 67*i));
      if (i < fdones.size())
        chk($sformatf("b2b fd %0d cyc", i), 32'(fdones[i]), 32'(67 + 67*i));
    end

    // Asynchronous reset mid-DRAIN with two commands still queued.
    do_reset();
    strobes.delete();
    for (int c = 0; c < 21; c++) begin
      v0 = (c < 3); d0 = 20'hABCDE; fs = (c == 4);
      #1;
      if (c == 20) begin
        chk("mid level", 32'(lvl), 32'd2);
        chk("mid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("async");
      end else begin
        next_cycle();
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (cv) strobes.push_back(c);
      next_cycle();
    end
    chk("post-reset strobes", 32'(strobes.size()), 32'd0);
    for (int c = 0; c < 5; c++) begin
      v0 = (c == 0); d0 = 20'h12345;
      #1;
      if (cv) strobes.push_back(c);
      next_cycle();
    end
    chk("post-reset new strobes", 32'(strobes.size()), 32'd1);
    if (strobes.size() == 1)
      chk("post-reset strobe cyc", 32'(strobes[0]), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
